count_monitor: RTL
==================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 4, is the width of the observed count.
REQ-002 Parameter MAX, default 15, is the upper turn-around value of the observed count (MAX <= 2^WIDTH-1, MAX >= 2).
REQ-003 Parameter STALL_LIM, default 8, is the number of consecutive unchanged samples that flags a stall (>= 2).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sample_en  input  1  strobe; count_in is sampled only on cycles where sample_en=1.
REQ-007 count_in  input  WIDTH  observed up/down triangle count from the producer.
REQ-008 dir  output  2  tracked direction: 00 unknown, 01 up, 10 down (11 never driven).
REQ-009 step_err  output  1  one-cycle pulse on an illegal step.
REQ-010 turn  output  1  one-cycle pulse on a legal turn-around (MAX->MAX-1 or 0->1).
REQ-011 stall  output  1  level; high while unchanged-sample run >= STALL_LIM.
REQ-012 err_cnt  output  8  saturating count of step_err pulses.
REQ-013 turn_cnt  output  8  saturating count of turn pulses.

Function
REQ-014 The block SHALL implement FSM states ACQ, SEEN1, UP, DOWN, held in a registered state with prev (WIDTH bits) holding the last accepted sample.
REQ-015 All outputs SHALL be registered; the response to a sample SHALL appear on the cycle after the sample_en cycle (latency 1); pulses last exactly one cycle.
REQ-016 Cycles with sample_en=0 SHALL change nothing except clearing step_err/turn pulses.
REQ-017 ACQ: on sample, prev<=count_in, go SEEN1; dir=00; no error possible.
REQ-018 SEEN1: sample = prev -> stay; prev+1 (prev<MAX) -> UP; prev-1 (prev>0) -> DOWN; else step_err, stay SEEN1; dir=00 while in SEEN1.
REQ-019 UP: prev<MAX and sample=prev+1 -> stay UP; prev=MAX and sample=MAX-1 -> DOWN with turn; sample=prev -> stay (hold); else step_err, go SEEN1.
REQ-020 DOWN: prev>0 and sample=prev-1 -> stay DOWN; prev=0 and sample=1 -> UP with turn; sample=prev -> stay (hold); else step_err, go SEEN1.
REQ-021 prev SHALL be updated to count_in on every sample, including erroneous ones.
REQ-022 Arithmetic SHALL be non-modular: MAX->0 and 0->MAX (wrap-around), and values > MAX, SHALL be step errors.
REQ-023 A hold run counter SHALL increment on each sample equal to prev, reset to 0 on any change, saturate at STALL_LIM; stall=1 when run >= STALL_LIM-1 after the current equal sample, cleared on the cycle after the next differing sample.
REQ-024 A hold SHALL not change dir or state; the producer idling (en low) is therefore legal.
REQ-025 err_cnt and turn_cnt SHALL saturate at 255 and never wrap.
REQ-026 Error and turn SHALL be mutually exclusive for one sample.

Reset
REQ-027 rst SHALL take priority over sample_en in the same cycle.
REQ-028 On rst: state=ACQ, prev=0, dir=00, step_err=0, turn=0, stall=0, run=0, err_cnt=0, turn_cnt=0.
REQ-029 rst asserted mid-sequence SHALL discard history; the first post-reset sample is never an error.

Structure
REQ-030 State encoding (ACQ, SEEN1, UP, DOWN) and dir codes (DIR_UNK, DIR_UP, DIR_DN) SHALL be constants in the shared counter package used by the counter FSM.
REQ-031 The two 8-bit saturating counters SHALL be one sub-module, sat_counter, instantiated twice.
REQ-032 The block SHALL be single-clock; crossing from a divided producer clock is the integrator's job (sample_en is synchronous to clk).

Verification
REQ-033 rst, then samples 0,1,2..15,14..0,1 -> dir 00,00,01.. up to 15, turn at 15->14 with dir 10, turn at 0->1 with dir 01; turn_cnt=2, err_cnt=0.
REQ-034 In UP at prev=5, sample 7 -> step_err one cycle, state SEEN1, dir 00, err_cnt=1; next sample 8 -> dir 01.
REQ-035 In UP at prev=15, sample 0 -> step_err (no wrap); in DOWN at prev=0, sample 15 -> step_err.
REQ-036 In DOWN at prev=9, eight samples of 9 -> stall=1 after the eighth, dir stays 10; sample 8 -> stall=0, dir 10, no error.
REQ-037 rst and sample_en=1 with count_in=7 in same cycle -> all outputs reset, state ACQ, sample ignored; next sample 3 -> no error, SEEN1.
REQ-038 300 illegal steps -> err_cnt holds 255; sample_en=0 gaps of any length -> no output change.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared constants for the triangle-count monitor: FSM state encoding and direction codes.
// Also holds the state-to-direction mapping used to register dir.
package count_monitor_pkg;

   typedef enum logic [1:0] {
      ACQ   = 2'd0,
      SEEN1 = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } state_t;

   localparam logic [1:0] DIR_UNK = 2'b00;
   localparam logic [1:0] DIR_UP  = 2'b01;
   localparam logic [1:0] DIR_DN  = 2'b10;

   function automatic logic [1:0] dir_of(input state_t s);
      case (s)
         UP:      dir_of = DIR_UP;
         DOWN:    dir_of = DIR_DN;
         default: dir_of = DIR_UNK;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count advances on inc and sticks at all-ones, latency 1.
// No backpressure; inc is a single-cycle strobe, synchronous reset clears to zero.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/count_monitor.sv
// Checks an up/down triangle count for legal steps, turn-arounds and stalls; latency 1.
// No backpressure: count_in is accepted on every sample_en strobe.
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX       = 15,
   parameter int STALL_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] count_in,
   output logic [1:0]       dir,
   output logic             step_err,
   output logic             turn,
   output logic             stall,
   output logic [7:0]       err_cnt,
   output logic [7:0]       turn_cnt
);

   localparam int RUN_W = $clog2(STALL_LIM + 1);
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_LIM);
   localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX);

   state_t           state;
   state_t           nstate;
   logic [WIDTH-1:0] prev;
   logic [RUN_W-1:0] run;
   logic             err_d;
   logic             turn_d;

   // One extra bit so prev+1 and prev-1 never wrap modulo 2^WIDTH.
   logic [WIDTH:0] in_x;
   logic [WIDTH:0] prev_x;
   logic           in_ok;
   logic           eq_ok;
   logic           step_up;
   logic           step_dn;
   logic           turn_at_max;
   logic           turn_at_zero;
   logic           same;

   assign in_x         = {1'b0, count_in};
   assign prev_x       = {1'b0, prev};
   assign in_ok        = (in_x <= MAX_X);
   assign same         = (count_in == prev);
   assign eq_ok        = in_ok && same;
   assign step_up      = in_ok && (prev_x < MAX_X) && (in_x == prev_x + 1'b1);
   assign step_dn      = in_ok && (prev_x <= MAX_X) && (prev != '0) && (in_x == prev_x - 1'b1);
   assign turn_at_max  = (prev_x == MAX_X) && (in_x == MAX_X - 1'b1);
   assign turn_at_zero = (prev == '0) && (in_x == (WIDTH + 1)'(1));

   always_comb begin
      nstate = state;
      err_d  = 1'b0;
      turn_d = 1'b0;
      case (state)
         ACQ: nstate = SEEN1;
         SEEN1: begin
            if (eq_ok) begin
               nstate = SEEN1;
            end else if (step_up) begin
               nstate = UP;
            end else if (step_dn) begin
               nstate = DOWN;
            end else begin
               err_d = 1'b1;
            end
         end
         UP: begin
            if (step_up || eq_ok) begin
               nstate = UP;
            end else if (turn_at_max) begin
               nstate = DOWN;
               turn_d = 1'b1;
            end else begin
               nstate = SEEN1;
               err_d  = 1'b1;
            end
         end
         DOWN: begin
            if (step_dn || eq_ok) begin
               nstate = DOWN;
            end else if (turn_at_zero) begin
               nstate = UP;
               turn_d = 1'b1;
            end else begin
               nstate = SEEN1;
               err_d  = 1'b1;
            end
         end
         default: nstate = ACQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACQ;
         prev     <= '0;
         dir      <= DIR_UNK;
         step_err <= 1'b0;
         turn     <= 1'b0;
         stall    <= 1'b0;
         run      <= '0;
      end else begin
         step_err <= 1'b0;
         turn     <= 1'b0;
         if (sample_en) begin
            state    <= nstate;
            prev     <= count_in;
            dir      <= dir_of(nstate);
            step_err <= err_d;
            turn     <= turn_d;
            // The first sample after reset has no history, so it starts a fresh run.
            if ((state != ACQ) && same) begin
               if (run != RUN_LIM) begin
                  run <= run + 1'b1;
               end
               stall <= (run >= RUN_LIM - 1'b1);
            end else begin
               run   <= '0;
               stall <= 1'b0;
            end
         end
      end
   end

   sat_counter #(.WIDTH(8)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (sample_en && err_d),
      .count (err_cnt)
   );

   sat_counter #(.WIDTH(8)) u_turn_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (sample_en && turn_d),
      .count (turn_cnt)
   );

endmodule
